// File: rtl/hrmpp_pkg.sv
// Shared widths, sizes and helpers for the placement pipeline output stage.
package hrmpp_pkg;

  localparam int unsigned W_WIDTH      = 8;
  localparam int unsigned W_ID         = 4;
  localparam int unsigned W_CNT        = 4;
  localparam int unsigned NUM_STRIPS   = 1 << W_ID;
  localparam int unsigned STRIP_HEIGHT = 8;

  // True when STRIP_HEIGHT is a power of two, so the y multiply reduces to a shift.
  localparam bit HEIGHT_IS_POW2 = (STRIP_HEIGHT != 0) && ((STRIP_HEIGHT & (STRIP_HEIGHT - 1)) == 0);

  // y origin of a strip: id * STRIP_HEIGHT, truncated to the index width.
  function automatic logic [W_WIDTH-1:0] strip_y(input logic [W_ID-1:0] id);
    logic [W_WIDTH+W_ID-1:0] prod;
    prod = (W_WIDTH + W_ID)'(id) * (W_WIDTH + W_ID)'(STRIP_HEIGHT);
    return prod[W_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/strip_state_table.sv
// Per-strip record of occupied width and closed ("struck") flag.
// One synchronous write port, combinational read of the addressed entry.
module strip_state_table
  import hrmpp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [W_ID-1:0]    wr_id,
  input  logic [W_WIDTH-1:0] wr_width,
  input  logic               wr_struck,
  input  logic [W_ID-1:0]    rd_id,
  output logic               rd_struck,
  output logic [W_WIDTH-1:0] rd_width
);

  logic [NUM_STRIPS-1:0][W_WIDTH-1:0] width_q, width_d;
  logic [NUM_STRIPS-1:0]              struck_q, struck_d;

  // Next-state of the table: only the addressed entry changes on a write.
  always_comb begin
    width_d  = width_q;
    struck_d = struck_q;
    if (wr_en) begin
      width_d[wr_id]  = wr_width;
      struck_d[wr_id] = wr_struck;
    end
  end

  // Table registers, cleared by reset regardless of any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q  <= '0;
      struck_q <= '0;
    end else begin
      width_q  <= width_d;
      struck_q <= struck_d;
    end
  end

  // Read port sees the registered table; a write lands one edge later.
  always_comb begin
    rd_struck = struck_q[rd_id];
    rd_width  = width_q[rd_id];
  end

endmodule

// File: rtl/end_part_top_module.sv
// Output stage of the placement pipeline: validates each placement against
// the strip table and registers the resulting (x, y) and strike count.
module end_part_top_module
  import hrmpp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               strike_flag_write,
  input  logic [W_ID-1:0]    strip_ID_write,
  input  logic [W_WIDTH-1:0] old_occupied_width_write,
  input  logic [W_WIDTH-1:0] new_occupied_width_write,
  input  logic [W_CNT-1:0]   strike_counter_write,
  output logic [W_WIDTH-1:0] index_x_output,
  output logic [W_WIDTH-1:0] index_y_output,
  output logic [W_CNT-1:0]   strike_counter_output
);

  logic               strip_struck;
  logic [W_WIDTH-1:0] strip_width;
  logic               write_ok;
  logic [W_WIDTH-1:0] y_origin;

  logic [W_WIDTH-1:0] index_x_q, index_x_d;
  logic [W_WIDTH-1:0] index_y_q, index_y_d;
  logic [W_CNT-1:0]   strike_cnt_q, strike_cnt_d;

  // The stored width is kept for downstream bookkeeping; the upstream old
  // width is authoritative for x, so the record is not consulted here.
  logic unused_strip_width;
  assign unused_strip_width = ^strip_width;

  strip_state_table u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (write_ok),
    .wr_id     (strip_ID_write),
    .wr_width  (new_occupied_width_write),
    .wr_struck (strike_flag_write),
    .rd_id     (strip_ID_write),
    .rd_struck (strip_struck),
    .rd_width  (strip_width)
  );

  // A placement is accepted only if it grows the strip and the strip is open.
  always_comb begin
    write_ok = (new_occupied_width_write > old_occupied_width_write) && !strip_struck;
  end

  // y origin of the target strip; a plain shift for power-of-two heights.
  always_comb begin
    if (HEIGHT_IS_POW2) begin
      y_origin = W_WIDTH'(strip_ID_write) << $clog2(STRIP_HEIGHT);
    end else begin
      y_origin = strip_y(strip_ID_write);
    end
  end

  // Output next-state: load on an accepted placement, otherwise hold.
  always_comb begin
    index_x_d    = index_x_q;
    index_y_d    = index_y_q;
    strike_cnt_d = strike_cnt_q;
    if (write_ok) begin
      index_x_d    = old_occupied_width_write;
      index_y_d    = y_origin;
      strike_cnt_d = strike_counter_write;
    end
  end

  // Output registers; reset wins over any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_x_q    <= '0;
      index_y_q    <= '0;
      strike_cnt_q <= '0;
    end else begin
      index_x_q    <= index_x_d;
      index_y_q    <= index_y_d;
      strike_cnt_q <= strike_cnt_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    index_x_output        = index_x_q;
    index_y_output        = index_y_q;
    strike_counter_output = strike_cnt_q;
  end

endmodule

// File: tb/tb_end_part_top_module.sv
// Bench for the placement output stage: directed vector table, a hand-written
// closed-strip sequence, then randomized traffic against a reference model.
module tb_end_part_top_module;

  logic       clk;
  logic       rst;
  logic       strike;
  logic [3:0] sid;
  logic [7:0] old_w;
  logic [7:0] new_w;
  logic [3:0] cnt_in;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [3:0] cnt_out;

  int tests_run;
  int tests_failed;

  end_part_top_module dut (
    .clk                      (clk),
    .rst                      (rst),
    .strike_flag_write        (strike),
    .strip_ID_write           (sid),
    .old_occupied_width_write (old_w),
    .new_occupied_width_write (new_w),
    .strike_counter_write     (cnt_in),
    .index_x_output           (x_out),
    .index_y_output           (y_out),
    .strike_counter_output    (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       strike;
    int         id;
    int         old_w;
    int         new_w;
    int         cnt;
    int         exp_x;
    int         exp_y;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[15];

  // Reference model state: which strips are closed and the last outputs.
  bit closed_m[16];
  int mx, my, mcnt;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic s, input int id, input int o, input int n, input int c);
    rst    = r;
    strike = s;
    sid    = id[3:0];
    old_w  = o[7:0];
    new_w  = n[7:0];
    cnt_in = c[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic s, input int id, input int o, input int n, input int c);
    if (r) begin
      foreach (closed_m[i]) closed_m[i] = 1'b0;
      mx = 0; my = 0; mcnt = 0;
    end else if (n > o && !closed_m[id]) begin
      mx = o;
      my = (id * 8) % 256;
      mcnt = c;
      closed_m[id] = s;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; strike = 1'b0; sid = '0; old_w = '0; new_w = '0; cnt_in = '0;

    //            rst  s    id  old  new  cnt   x    y    cnt
    vecs[0]  = '{1'b1, 1'b0, 0,   0,   0,  0,   0,   0,   0};
    vecs[1]  = '{1'b0, 1'b0, 3,  10,  10,  5,   0,   0,   0};
    vecs[2]  = '{1'b0, 1'b1, 7,  50,  20,  9,   0,   0,   0};
    vecs[3]  = '{1'b0, 1'b1, 1,   0,  16,  1,   0,   8,   1};
    vecs[4]  = '{1'b0, 1'b0, 5,  21,  27,  2,  21,  40,   2};
    vecs[5]  = '{1'b0, 1'b0, 8,  52,  70, 10,  52,  64,  10};
    vecs[6]  = '{1'b0, 1'b0, 1,  16,  30,  3,  52,  64,  10};
    vecs[7]  = '{1'b0, 1'b0, 2,  40,  40,  4,  52,  64,  10};
    vecs[8]  = '{1'b0, 1'b0, 2,  40,  41,  4,  40,  16,   4};
    vecs[9]  = '{1'b0, 1'b0, 15, 200, 255, 15, 200, 120,  15};
    vecs[10] = '{1'b1, 1'b1, 4,   3,   9,  6,   0,   0,   0};
    vecs[11] = '{1'b0, 1'b0, 1,   0,   5,  1,   0,   8,   1};
    vecs[12] = '{1'b0, 1'b1, 0,   3,   4, 14,   3,   0,  14};
    vecs[13] = '{1'b0, 1'b0, 0,   4,   9, 15,   3,   0,  14};
    vecs[14] = '{1'b0, 1'b0, 0, 255,   0,  7,   3,   0,  14};

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].rst, vecs[i].strike, vecs[i].id, vecs[i].old_w, vecs[i].new_w, vecs[i].cnt);
      check($sformatf("vec%0d_x", i),   int'(x_out),   vecs[i].exp_x);
      check($sformatf("vec%0d_y", i),   int'(y_out),   vecs[i].exp_y);
      check($sformatf("vec%0d_cnt", i), int'(cnt_out), vecs[i].exp_cnt);
    end

    // Closing write to strip 9, then several growing writes that must all bounce.
    apply(1'b0, 1'b1, 9, 30, 60, 11);
    check("close9_x", int'(x_out), 30);
    check("close9_y", int'(y_out), 72);
    check("close9_cnt", int'(cnt_out), 11);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, k[0], 9, 60 + k, 100 + k, k + 1);
      check($sformatf("hold9_%0d_x", k), int'(x_out), 30);
      check($sformatf("hold9_%0d_cnt", k), int'(cnt_out), 11);
    end
    // A different strip still accepts after strip 9 closed.
    apply(1'b0, 1'b0, 10, 7, 8, 3);
    check("open10_y", int'(y_out), 80);

    // Randomized traffic against the reference model.
    apply(1'b1, 1'b0, 0, 0, 0, 0);
    model_step(1'b1, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      logic r, s;
      int id, o, nw, c;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 7) == 0);
      id = (n % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      o  = int'($urandom_range(0, 255));
      nw = int'($urandom_range(0, 255));
      c  = int'($urandom_range(0, 15));
      apply(r, s, id, o, nw, c);
      model_step(r, s, id, o, nw, c);
      check("rand_x", int'(x_out), mx);
      check("rand_y", int'(y_out), my);
      check("rand_cnt", int'(cnt_out), mcnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/end_part_top_module.md
Name: end_part_top_module

Overview:
Final (output) stage of the multi-program placement pipeline. It takes the placement decision from upstream: target strip, old and new occupied width, strike flag and strike count. From these it produces the registered placement coordinates (x, y) and passes the strike count through. It also keeps a per-strip record of occupied width and a "struck" (closed) flag, and uses that record to reject writes to closed strips.

Parameters:
NUM_STRIPS, 16, number of strips; must equal 2^width(strip_ID_write).
STRIP_HEIGHT, 8, height of one strip in index units; index_y = strip_ID * STRIP_HEIGHT.
W_WIDTH, 8, bit width of occupied-width and index values.
W_ID, 4, bit width of strip ID.
W_CNT, 4, bit width of strike counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, synchronous and active-high.
strike_flag_write  input  1  1 = this placement closes (strikes) its strip.
strip_ID_write  input  W_ID  target strip of the placement.
old_occupied_width_write  input  W_WIDTH  strip occupied width before placement; this is the x start of the program.
new_occupied_width_write  input  W_WIDTH  strip occupied width after placement.
strike_counter_write  input  W_CNT  running strike count from upstream.
index_x_output  output  W_WIDTH  registered x coordinate of the placed program.
index_y_output  output  W_WIDTH  registered y coordinate of the placed program.
strike_counter_output  output  W_CNT  registered strike count.

Behaviour:
- Synchronous reset (rst=1 at a rising edge):
  - index_x_output, index_y_output and strike_counter_output become 0.
  - All strip widths become 0 and all struck flags become 0.
  - Reset takes priority over any write in the same cycle and may be asserted at any time.
- Valid write: new_occupied_width_write > old_occupied_width_write (unsigned) AND struck[strip_ID_write]==0. Inputs are sampled every cycle; there is no separate valid signal.
- On a valid write, at the next rising edge (latency 1 cycle):
  - index_x_output <= old_occupied_width_write.
  - index_y_output <= strip_ID_write * STRIP_HEIGHT, truncated to W_WIDTH (15*8=120, no overflow at defaults).
  - strike_counter_output <= strike_counter_write.
  - width[strip] <= new_occupied_width_write.
  - struck[strip] <= strike_flag_write.
- Invalid write (new <= old, or strip already struck): all outputs and all table state hold their previous values.
- The old width input is authoritative for index_x_output. It is not compared against width[strip]; mismatches are not flagged.
- Once a strip is struck, it stays closed until reset.
- A write with strike_flag_write=1 is itself accepted; it is the last accepted write to that strip.
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- A strike_counter_write wrap-around is passed through unchanged.

Decomposition:
- Shared package, hrmpp_pkg: W_WIDTH, W_ID, W_CNT, NUM_STRIPS, STRIP_HEIGHT.
- One sub-module, strip_state_table:
  - holds the NUM_STRIPS x W_WIDTH width array and the NUM_STRIPS struck flags;
  - has a synchronous write port and a combinational read of struck[strip_ID];
  - clears everything on rst.
- The top level holds the validity logic, the y multiply (a shift when STRIP_HEIGHT is a power of two) and the output registers.

Test Plan:
1. Reset: rst=1 for one edge -> all outputs 0. Then drive new<=old every cycle -> outputs remain 0.
2. Sequential writes, one per cycle, each checked one cycle after it is driven:
   - (strike=1, ID=1, old=0, new=16, cnt=1) -> x=0, y=8, cnt=1.
   - (strike=0, ID=5, old=21, new=27, cnt=2) -> x=21, y=40, cnt=2.
   - (strike=0, ID=8, old=52, new=70, cnt=10) -> x=52, y=64, cnt=10.
3. Struck strip rejection: after step 2 (strip 1 struck), drive ID=1, old=16, new=30, cnt=3 -> outputs hold x=52, y=64, cnt=10.
4. Invalid width: ID=2, old=40, new=40 -> outputs hold. Then ID=2, old=40, new=41, cnt=4 -> x=40, y=16, cnt=4.
5. Boundary strip: ID=15, old=200, new=255, cnt=15 -> x=200, y=120, cnt=15.
6. Reset mid-operation: assert rst in the same cycle as a valid write -> outputs 0. Afterwards, strip 1 accepts ID=1, old=0, new=5 -> x=0, y=8 (struck flag cleared).
